// File: rtl/cdc_sched_pkg.sv
// rtl/cdc_sched_pkg.sv - shared types and helpers for cdc_bus launch schedulers
package cdc_sched_pkg;

    typedef enum logic {IDLE, GAP} state_t;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdc_bus_sched_rr_pick.sv
// rtl/cdc_bus_sched_rr_pick.sv - combinational round-robin picker, first valid at or after ptr
module rr_pick #(
    parameter int N    = 4,
    parameter int TAGW = 2
) (
    input  logic [N-1:0]    req_valid,
    input  logic [TAGW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [TAGW-1:0] idx
);

    int j;

    // Scan from the farthest candidate back to ptr so the nearest hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req_valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = TAGW'(j);
            end
        end
    end

endmodule

// File: rtl/cdc_bus_sched.sv
// rtl/cdc_bus_sched.sv - round-robin scheduler with launch spacing in front of one cdc_bus crossing
module cdc_bus_sched
    import cdc_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int TAGW    = tag_w(N),
    parameter int HOLDOFF = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic [N-1:0]          req_valid,
    input  logic [N*WIDTH-1:0]    req_data,
    output logic [N-1:0]          req_ready,
    output logic                  out_en,
    output logic [TAGW+WIDTH-1:0] out_bus,
    output logic                  busy
);

    localparam int CW = $clog2(HOLDOFF + 1);

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [TAGW-1:0] ptr;
    logic [TAGW-1:0] pick_idx;
    logic [N-1:0]    pick_grant;
    logic            launch;
    state_t          state;

    rr_pick #(
        .N    (N),
        .TAGW (TAGW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .idx       (pick_idx)
    );

    assign state     = (cnt == '0) ? IDLE : GAP;
    assign req_ready = (state == IDLE && !pause) ? pick_grant : '0;
    assign launch    = |req_ready;

    always_comb begin
        cnt_next = cnt;
        if (launch)
            cnt_next = CW'(HOLDOFF - 1);
        else if (cnt != '0)
            cnt_next = cnt - CW'(1);
    end

    // Reset starts in GAP: a word launched just before reset may still be crossing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= CW'(HOLDOFF - 1);
            busy    <= (HOLDOFF > 1);
            ptr     <= '0;
            out_en  <= 1'b0;
            out_bus <= '0;
        end else begin
            cnt    <= cnt_next;
            busy   <= (cnt_next != '0);
            out_en <= launch;
            if (launch) begin
                out_bus <= {pick_idx, req_data[int'(pick_idx)*WIDTH +: WIDTH]};
                ptr     <= (int'(pick_idx) == N - 1) ? '0 : pick_idx + TAGW'(1);
            end
        end
    end

endmodule
